// File: rtl/irrigation_pkg.sv
// Shared state encodings, timer defaults and sensor helpers for the irrigation controller.
// Combinational helpers only; nothing here holds state.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    IRRIGATE = 2'd2,
    FAULT    = 2'd3
  } state_t;

  // Zone indices and the active_zone display share this width.
  localparam int ZONE_IDX_W = 3;

  localparam int DEF_ZONES        = 4;
  localparam int DEF_TIMER_W      = 8;
  localparam int DEF_IRR_TIME     = 50;
  localparam int DEF_FILL_TIMEOUT = 200;

  // A full reading above an empty reading cannot happen with healthy sensors.
  function automatic logic sensor_fault(input logic tank_high, input logic tank_low);
    return tank_high && !tank_low;
  endfunction

endpackage

// File: rtl/irrigation_zone_controller_if.sv
// Sensor-side inputs and valve/display outputs of the irrigation controller.
// master drives sensors and reads valves; slave is the controller itself.
interface irrigation_zone_controller_if
  import irrigation_pkg::*;
#(
  parameter int ZONES = DEF_ZONES
);

  logic                  enable;
  logic                  tick;
  logic                  tank_high;
  logic                  tank_low;
  logic [ZONES-1:0]      soil_dry;

  logic                  inlet_valve;
  logic [ZONES-1:0]      zone_valve;
  logic                  alarm;
  logic [1:0]            state_q;
  logic [ZONE_IDX_W-1:0] active_zone;

  modport master (
    output enable, tick, tank_high, tank_low, soil_dry,
    input  inlet_valve, zone_valve, alarm, state_q, active_zone
  );

  modport slave (
    input  enable, tick, tank_high, tank_low, soil_dry,
    output inlet_valve, zone_valve, alarm, state_q, active_zone
  );

endinterface

// File: rtl/rr_zone_arbiter.sv
// Round-robin pick of the first requesting zone after last_zone, wrapping at ZONES.
// Purely combinational; grant is meaningful only when any_req is high.
module rr_zone_arbiter
  import irrigation_pkg::*;
#(
  parameter int ZONES = DEF_ZONES
) (
  input  logic [ZONES-1:0]      req,
  input  logic [ZONE_IDX_W-1:0] last_zone,
  output logic [ZONE_IDX_W-1:0] grant,
  output logic                  any_req
);

  int idx;

  // Walk the candidates farthest-first so the nearest requester overwrites the rest.
  always_comb begin
    grant   = '0;
    any_req = |req;
    idx     = 0;
    for (int k = ZONES; k >= 1; k--) begin
      idx = (int'(last_zone) + k) % ZONES;
      if ((req & (ZONES'(1) << idx)) != '0) begin
        grant = ZONE_IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_controller.sv
// Reservoir fill plus round-robin zone irrigation with pause/resume and a sticky fault.
// Outputs are registered decodes of the next state, so inputs show up one clock later.
module irrigation_zone_controller
  import irrigation_pkg::*;
#(
  parameter int ZONES        = DEF_ZONES,
  parameter int TIMER_W      = DEF_TIMER_W,
  parameter int IRR_TIME     = DEF_IRR_TIME,
  parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
  input logic                          clock,
  input logic                          reset,
  irrigation_zone_controller_if.slave  bus
);

  localparam logic [TIMER_W-1:0]    IRR_LOAD   = TIMER_W'(IRR_TIME);
  localparam logic [TIMER_W-1:0]    FILL_LIMIT = TIMER_W'(FILL_TIMEOUT);
  localparam logic [ZONE_IDX_W-1:0] LAST_INIT  = ZONE_IDX_W'(ZONES - 1);

  state_t                state, state_d;
  logic [ZONE_IDX_W-1:0] active, active_d;
  logic [ZONE_IDX_W-1:0] last_zone, last_zone_d;
  logic                  paused, paused_d;
  logic [TIMER_W-1:0]    remaining, remaining_d;
  logic [TIMER_W-1:0]    fill_timer, fill_timer_d;

  logic [ZONE_IDX_W-1:0] grant;
  logic                  any_req;
  logic                  fault_in;
  logic                  active_dry;
  logic                  done;

  logic                  inlet_d;
  logic                  alarm_d;
  logic [ZONES-1:0]      zone_valve_d;
  logic [ZONE_IDX_W-1:0] active_zone_d;

  rr_zone_arbiter #(
    .ZONES (ZONES)
  ) u_arb (
    .req       (bus.soil_dry),
    .last_zone (last_zone),
    .grant     (grant),
    .any_req   (any_req)
  );

  assign fault_in   = sensor_fault(bus.tank_high, bus.tank_low);
  assign active_dry = (bus.soil_dry & (ZONES'(1) << active)) != '0;
  // The visit ends on the tick that would take remaining to zero, or when the soil is wet.
  assign done       = (bus.tick && (remaining == TIMER_W'(1))) || !active_dry;

  always_comb begin
    state_d      = state;
    active_d     = active;
    last_zone_d  = last_zone;
    paused_d     = paused;
    remaining_d  = remaining;
    fill_timer_d = fill_timer;

    case (state)
      IDLE: begin
        if (fault_in) begin
          state_d = FAULT;
        end else if (bus.enable) begin
          if (!bus.tank_low) begin
            state_d = FILL;
          end else if (any_req) begin
            state_d     = IRRIGATE;
            active_d    = grant;
            remaining_d = IRR_LOAD;
          end
        end
      end

      FILL: begin
        if (bus.tick) begin
          fill_timer_d = fill_timer + TIMER_W'(1);
        end
        if (fault_in) begin
          state_d = FAULT;
        end else if (!bus.enable) begin
          state_d  = IDLE;
          paused_d = 1'b0;
        end else if (bus.tank_high) begin
          // A paused visit resumes with whatever remaining count it was holding.
          if (paused) begin
            state_d  = IRRIGATE;
            paused_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (fill_timer == FILL_LIMIT) begin
          state_d = FAULT;
        end
      end

      IRRIGATE: begin
        if (bus.tick && (remaining != '0)) begin
          remaining_d = remaining - TIMER_W'(1);
        end
        if (fault_in) begin
          state_d = FAULT;
        end else if (!bus.enable) begin
          state_d  = IDLE;
          paused_d = 1'b0;
        end else if (done) begin
          state_d     = IDLE;
          last_zone_d = active;
        end else if (!bus.tank_low) begin
          state_d  = FILL;
          paused_d = 1'b1;
        end
      end

      FAULT: begin
        if (!bus.enable && !fault_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == FILL) && (state != FILL)) begin
      fill_timer_d = '0;
    end
    if (state_d == FAULT) begin
      paused_d = 1'b0;
    end

    inlet_d       = (state_d == FILL);
    alarm_d       = (state_d == FAULT);
    zone_valve_d  = (state_d == IRRIGATE) ? (ZONES'(1) << active_d) : '0;
    active_zone_d = ((state_d == IRRIGATE) || ((state_d == FILL) && paused_d))
                    ? (active_d + ZONE_IDX_W'(1)) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      active          <= '0;
      last_zone       <= LAST_INIT;
      paused          <= 1'b0;
      remaining       <= '0;
      fill_timer      <= '0;
      bus.inlet_valve <= 1'b0;
      bus.zone_valve  <= '0;
      bus.alarm       <= 1'b0;
      bus.state_q     <= IDLE;
      bus.active_zone <= '0;
    end else begin
      state           <= state_d;
      active          <= active_d;
      last_zone       <= last_zone_d;
      paused          <= paused_d;
      remaining       <= remaining_d;
      fill_timer      <= fill_timer_d;
      bus.inlet_valve <= inlet_d;
      bus.zone_valve  <= zone_valve_d;
      bus.alarm       <= alarm_d;
      bus.state_q     <= state_d;
      bus.active_zone <= active_zone_d;
    end
  end

  // At most one zone open, and never while the reservoir is filling.
  assert property (@(posedge clock) disable iff (reset) $onehot0(bus.zone_valve));
  assert property (@(posedge clock) disable iff (reset) !(bus.inlet_valve && (bus.zone_valve != '0)));

endmodule
